// File: rtl/otter_pkg.sv
// ============================================================================
// Module      : otter_pkg
// Description : Shared OTTER pipeline types and constants. Holds the RV32I
//               major opcode enumeration used by decode and the hazard unit,
//               the default reset PC and bubble encoding, and the fetch
//               stage state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package otter_pkg;

   // RV32I major opcodes (instr[6:0]).
   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   // addi x0,x0,0: architecturally a no-op, used as the pipeline bubble.
   localparam logic [31:0] OTTER_NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] OTTER_RESET_PC  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

endpackage : otter_pkg

`default_nettype wire

// File: rtl/otter_fetch_stage_if.sv
// ============================================================================
// Module      : otter_fetch_stage_if
// Description : Instruction-memory read bus between the fetch stage (master)
//               and the instruction memory (slave).
//   req   master->slave  read request, address held while req=1 and ack=0
//   addr  master->slave  word-aligned fetch address
//   ack   slave->master  response valid this cycle
//   rdata slave->master  instruction word, meaningful only when ack=1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface otter_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface : otter_fetch_stage_if

`default_nettype wire

// File: rtl/otter_fetch_skid.sv
// ============================================================================
// Module      : otter_fetch_skid
// Description : Single-entry skid register for the fetch stage. Captures an
//               instruction that returns from memory while decode is stalled
//               so the request can retire; the top drains it once the stall
//               releases.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_fetch     fetch stage is in its FETCH state
//   ack, rdata   memory response
//   drop         response belongs to a request cancelled by an earlier flush
//   flush        redirect this cycle (response discarded)
//   reg_en       0 = decode stalled
//   load         response is being parked this cycle (top enters HOLD)
//   hold_ir      parked instruction
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_fetch_skid (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        in_fetch,
   input  wire logic        ack,
   input  wire logic [31:0] rdata,
   input  wire logic        drop,
   input  wire logic        flush,
   input  wire logic        reg_en,
   output logic             load,
   output logic [31:0]      hold_ir
);

   // Park only a live response that decode cannot accept; a flush in the
   // same cycle throws the word away instead.
   assign load = in_fetch & ack & ~drop & ~flush & ~reg_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_ir <= 32'h0000_0000;
      end else if (load) begin
         hold_ir <= rdata;
      end
   end

endmodule : otter_fetch_skid

`default_nettype wire

// File: rtl/otter_fetch_stage.sv
// ============================================================================
// Module      : otter_fetch_stage
// Description : OTTER IF stage plus IF/DE pipeline register. Owns the PC,
//               issues one instruction read at a time over the imem bus,
//               honours decode stalls (reg_en) and execute redirects (flush),
//               and inserts NOP bubbles on memory wait or flush.
//   clk, rst_n    clock, asynchronous active-low reset
//   reg_en        0 = hold PC and IF/DE register
//   flush         taken branch/jump, flush_target is the new PC
//   imem          instruction memory bus (master side)
//   de_ir, de_pc  IF/DE instruction and its PC
//   de_valid      0 = de_ir is a bubble
//   bubble_cnt    saturating count of bubbles caused by memory wait
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_fetch_stage
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = OTTER_RESET_PC,
   parameter logic [31:0] NOP_INSTR = OTTER_NOP_INSTR,
   parameter int          CNT_W     = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             reg_en,
   input  wire logic             flush,
   input  wire logic [31:0]      flush_target,
   otter_fetch_stage_if.master   imem,
   output logic      [31:0]      de_ir,
   output logic      [31:0]      de_pc,
   output logic                  de_valid,
   output logic      [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   fetch_state_t state;
   logic [31:0]  pc_q;
   logic [31:0]  redir_q;
   logic         drop;
   logic         req_q;
   logic         load_hold;
   logic [31:0]  hold_ir;

   wire logic [31:0] pc_inc   = pc_q + 32'd4;
   wire logic [31:0] flush_pc = flush_target & ~32'h0000_0003;

   assign imem.req  = req_q;
   assign imem.addr = pc_q;

   otter_fetch_skid u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_fetch (state == ST_FETCH),
      .ack      (imem.ack),
      .rdata    (imem.rdata),
      .drop     (drop),
      .flush    (flush),
      .reg_en   (reg_en),
      .load     (load_hold),
      .hold_ir  (hold_ir)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pc_q       <= RESET_PC;
         redir_q    <= 32'h0000_0000;
         drop       <= 1'b0;
         req_q      <= 1'b0;
         de_ir      <= NOP_INSTR;
         de_pc      <= 32'h0000_0000;
         de_valid   <= 1'b0;
         bubble_cnt <= '0;
      end else if (flush) begin
         de_ir    <= NOP_INSTR;
         de_valid <= 1'b0;
         state    <= ST_FETCH;
         req_q    <= 1'b1;
         if (state == ST_FETCH && !imem.ack) begin
            // Request still in flight: keep the address stable, remember
            // where to go, and discard its response when it arrives.
            drop    <= 1'b1;
            redir_q <= flush_pc;
         end else begin
            pc_q <= flush_pc;
            drop <= 1'b0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_FETCH;
               req_q <= 1'b1;
            end
            ST_FETCH: begin
               if (imem.ack) begin
                  if (drop) begin
                     pc_q <= redir_q;
                     drop <= 1'b0;
                     if (reg_en) begin
                        de_ir    <= NOP_INSTR;
                        de_valid <= 1'b0;
                     end
                  end else if (reg_en) begin
                     de_ir    <= imem.rdata;
                     de_pc    <= pc_q;
                     de_valid <= 1'b1;
                     pc_q     <= pc_inc;
                  end else if (load_hold) begin
                     state <= ST_HOLD;
                     req_q <= 1'b0;
                  end
               end else if (reg_en) begin
                  de_ir    <= NOP_INSTR;
                  de_valid <= 1'b0;
                  if (bubble_cnt != {CNT_W{1'b1}}) begin
                     bubble_cnt <= bubble_cnt + CNT_ONE;
                  end
               end
            end
            ST_HOLD: begin
               if (reg_en) begin
                  de_ir    <= hold_ir;
                  de_pc    <= pc_q;
                  de_valid <= 1'b1;
                  pc_q     <= pc_inc;
                  state    <= ST_FETCH;
                  req_q    <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule : otter_fetch_stage

`default_nettype wire
